// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared constants and the controller state type for the instruction memory
// server. Fetch/decode logic can import the same INSTR_W, DEPTH_LOG2 and
// NOP_INSTR so that everyone agrees on word width, depth and the filler word.
// -----------------------------------------------------------------------------
package instr_mem_pkg;

    localparam int INSTR_W    = 9;
    localparam int DEPTH_LOG2 = 10;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 9'h000;

    // Controller states; encoding is also visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_ram.sv
// -----------------------------------------------------------------------------
// instr_ram
// Single-port instruction array: synchronous write, synchronous read with one
// cycle of latency. A write cycle does not update the read register, so the
// port is either reading or writing in any given cycle. The array itself has
// no reset.
//
// Ports:
//   i_clk    clock, all activity on the rising edge
//   i_addr   word address (shared by read and write)
//   i_we     write enable; writes i_wdata to mem[i_addr]
//   i_wdata  write data
//   o_rdata  data for the address sampled on the previous rising edge
// -----------------------------------------------------------------------------
module instr_ram #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_server.sv
// -----------------------------------------------------------------------------
// instr_mem_server
// Responder end of the instruction-fetch interface plus a streaming program
// loader. A program image is streamed in (LOAD), after which fetch addresses
// are served with one cycle of latency (RUN). Fetch is told to stall whenever
// no program is being served.
//
// Loader handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high; load_ready depends only on controller state and
// the load pointer, never on load_valid. load_done ends the load on the edge
// it is seen, counting a word transferred on that same edge.
//
// Ports:
//   CLK          system clock
//   reset_ctrl   asynchronous active-high reset
//   instr_addr   fetch address from the fetch stage
//   instr_out    instruction for the address sampled on the previous edge
//   instr_valid  instr_out is a real fetch response
//   fetch_stall  high whenever the controller is not in RUN
//   addr_fault   response was for an address >= prog_len (instr_out = NOP)
//   load_start   pulse: begin (or restart) a load at address 0
//   load_valid   load_data holds a word to write
//   load_data    program word
//   load_ready   loader accepts a word this cycle
//   load_done    end of load
//   prog_len     number of words resident (0..2**DEPTH_LOG2)
//   dbg_state    current controller state (state_t encoding)
// -----------------------------------------------------------------------------
module instr_mem_server #(
    parameter int INSTR_W    = instr_mem_pkg::INSTR_W,
    parameter int DEPTH_LOG2 = instr_mem_pkg::DEPTH_LOG2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = instr_mem_pkg::NOP_INSTR
) (
    input  logic                  CLK,
    input  logic                  reset_ctrl,
    input  logic [15:0]           instr_addr,
    output logic [INSTR_W-1:0]    instr_out,
    output logic                  instr_valid,
    output logic                  fetch_stall,
    output logic                  addr_fault,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [INSTR_W-1:0]    load_data,
    output logic                  load_ready,
    input  logic                  load_done,
    output logic [DEPTH_LOG2:0]   prog_len,
    output logic [1:0]            dbg_state
);

    import instr_mem_pkg::*;

    localparam int PTR_W = DEPTH_LOG2 + 1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [PTR_W-1:0]        r_load_ptr;
    logic [PTR_W-1:0]        r_prog_len;
    logic [PTR_W-1:0]        w_ptr_next;
    logic                    r_resp_valid;
    logic                    r_resp_fault;
    logic                    w_accept;
    logic                    w_fetch;
    logic                    w_restart;
    logic                    w_fault;
    logic [DEPTH_LOG2-1:0]   w_mem_addr;
    logic [INSTR_W-1:0]      w_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded controls
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        load_ready   = 1'b0;
        fetch_stall  = 1'b1;
        w_fetch      = 1'b0;
        w_restart    = 1'b0;
        w_mem_addr   = instr_addr[DEPTH_LOG2-1:0];
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_next_state = LOAD;
                    w_restart    = 1'b1;
                end
            end
            LOAD: begin
                // Pointer MSB set means the array is full.
                load_ready = ~r_load_ptr[DEPTH_LOG2];
                w_mem_addr = r_load_ptr[DEPTH_LOG2-1:0];
                if (load_start) begin
                    w_restart = 1'b1;
                end else if (load_done) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                fetch_stall = 1'b0;
                if (load_start) begin
                    // The fetch sampled on this edge is dropped.
                    w_next_state = LOAD;
                    w_restart    = 1'b1;
                end else begin
                    w_fetch = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept   = load_valid & load_ready;
    assign w_ptr_next = r_load_ptr + {{DEPTH_LOG2{1'b0}}, w_accept};

    // Unsigned compare on the full 16-bit address so high bits fault too.
    assign w_fault = (instr_addr >= {{(16-PTR_W){1'b0}}, r_prog_len});

    // ------------------------------------------------------------------
    // Load pointer and program length
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            r_load_ptr <= '0;
            r_prog_len <= '0;
        end else if (w_restart) begin
            r_load_ptr <= '0;
            r_prog_len <= '0;
        end else if (r_state == LOAD) begin
            r_load_ptr <= w_ptr_next;
            if (load_done) begin
                r_prog_len <= w_ptr_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch response qualifiers, aligned with the RAM read data
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
        end else begin
            r_resp_valid <= w_fetch;
            r_resp_fault <= w_fetch & w_fault;
        end
    end

    instr_ram #(
        .DATA_W (INSTR_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (CLK),
        .i_addr  (w_mem_addr),
        .i_we    (w_accept),
        .i_wdata (load_data),
        .o_rdata (w_rdata)
    );

    // RAM data is only exposed for a real, in-range response; the array has
    // no reset, so everything else shows the filler word.
    assign instr_out   = (r_resp_valid && !r_resp_fault) ? w_rdata : NOP_INSTR;
    assign instr_valid = r_resp_valid;
    assign addr_fault  = r_resp_fault;
    assign prog_len    = r_prog_len;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_mem_server.sv
module tb_instr_mem_server;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [8:0] NOP     = 9'h000;

    logic        CLK;
    logic        reset_ctrl;
    logic [15:0] instr_addr;
    logic [8:0]  instr_out;
    logic        instr_valid;
    logic        fetch_stall;
    logic        addr_fault;
    logic        load_start;
    logic        load_valid;
    logic [8:0]  load_data;
    logic        load_ready;
    logic        load_done;
    logic [10:0] prog_len;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_miss;

    instr_mem_server dut (
        .CLK         (CLK),
        .reset_ctrl  (reset_ctrl),
        .instr_addr  (instr_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall),
        .addr_fault  (addr_fault),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .prog_len    (prog_len),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pattern for the full-memory image, word k is 1-based.
    function automatic logic [8:0] word_val(input int k);
        logic [31:0] t;
        t = k * 7 + 3;
        return t[8:0];
    endfunction

    // ---------------- drivers (enter and leave at a falling edge) ----------------
    task automatic start_load();
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    task automatic drive_load(input logic [8:0] d, input logic done);
        load_valid = 1'b1;
        load_data  = d;
        load_done  = done;
        @(negedge CLK);
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic drive_done();
        load_done = 1'b1;
        @(negedge CLK);
        load_done = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a);
        instr_addr = a;
        @(negedge CLK);
    endtask

    task automatic check_resp(input string tag, input logic [8:0] exp_instr, input logic exp_fault);
        check({tag, " instr"}, instr_out, exp_instr);
        check({tag, " valid"}, instr_valid, 1'b1);
        check({tag, " fault"}, addr_fault, exp_fault);
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        reset_ctrl = 1'b1;
        instr_addr = 16'h0000;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 9'h000;
        load_done  = 1'b0;

        // ---------------- reset state ----------------
        @(negedge CLK);
        @(negedge CLK);
        check("rst state", dbg_state, ST_IDLE);
        check("rst instr_out", instr_out, NOP);
        check("rst instr_valid", instr_valid, 1'b0);
        check("rst addr_fault", addr_fault, 1'b0);
        check("rst load_ready", load_ready, 1'b0);
        check("rst fetch_stall", fetch_stall, 1'b1);
        check("rst prog_len", prog_len, 11'd0);
        reset_ctrl = 1'b0;
        @(negedge CLK);

        // ---------------- reset mid-load ----------------
        start_load();
        check("ml state", dbg_state, ST_LOAD);
        check("ml load_ready", load_ready, 1'b1);
        drive_load(9'h011, 1'b0);
        drive_load(9'h022, 1'b0);
        drive_load(9'h033, 1'b0);
        #2 reset_ctrl = 1'b1;
        #1;
        check("ml rst state", dbg_state, ST_IDLE);
        check("ml rst load_ready", load_ready, 1'b0);
        check("ml rst fetch_stall", fetch_stall, 1'b1);
        check("ml rst prog_len", prog_len, 11'd0);
        check("ml rst instr_valid", instr_valid, 1'b0);
        @(negedge CLK);
        reset_ctrl = 1'b0;
        @(negedge CLK);

        // ---------------- load and run ----------------
        start_load();
        drive_load(9'h101, 1'b0);
        drive_load(9'h0A2, 1'b0);
        drive_load(9'h1FF, 1'b1);
        check("lr state", dbg_state, ST_RUN);
        check("lr prog_len", prog_len, 11'd3);
        check("lr fetch_stall", fetch_stall, 1'b0);
        check("lr valid before fetch", instr_valid, 1'b0);
        check("lr load_ready", load_ready, 1'b0);
        fetch(16'd0);
        check_resp("lr a0", 9'h101, 1'b0);
        fetch(16'd1);
        check_resp("lr a1", 9'h0A2, 1'b0);
        fetch(16'd2);
        check_resp("lr a2", 9'h1FF, 1'b0);

        // ---------------- fault ----------------
        fetch(16'd3);
        check_resp("flt a3", NOP, 1'b1);
        fetch(16'h8000);
        check_resp("flt a8000", NOP, 1'b1);
        fetch(16'd0);
        check_resp("flt a0", 9'h101, 1'b0);

        // ---------------- full memory ----------------
        start_load();
        check("fm prog_len cleared", prog_len, 11'd0);
        for (int k = 1; k <= 1023; k++) begin
            drive_load(word_val(k), 1'b0);
        end
        check("fm ready before last", load_ready, 1'b1);
        drive_load(word_val(1024), 1'b0);
        check("fm ready after 1024", load_ready, 1'b0);
        drive_load(9'h1AA, 1'b0);
        check("fm ready after drop", load_ready, 1'b0);
        check("fm state loading", dbg_state, ST_LOAD);
        drive_done();
        check("fm state run", dbg_state, ST_RUN);
        check("fm prog_len", prog_len, 11'd1024);
        fetch(16'd1023);
        check_resp("fm a1023", word_val(1024), 1'b0);
        fetch(16'd0);
        check_resp("fm a0", word_val(1), 1'b0);
        fetch(16'd512);
        check_resp("fm a512", word_val(513), 1'b0);
        fetch(16'd1024);
        check_resp("fm a1024", NOP, 1'b1);

        // ---------------- reload during RUN, done with first word ----------------
        instr_addr = 16'd5;
        start_load();
        check("rl instr_valid", instr_valid, 1'b0);
        check("rl fetch_stall", fetch_stall, 1'b1);
        check("rl state", dbg_state, ST_LOAD);
        check("rl prog_len", prog_len, 11'd0);
        drive_load(9'h055, 1'b1);
        check("rl state run", dbg_state, ST_RUN);
        check("rl prog_len one", prog_len, 11'd1);
        fetch(16'd0);
        check_resp("rl a0", 9'h055, 1'b0);
        fetch(16'd1);
        check_resp("rl a1", NOP, 1'b1);

        // ---------------- load_done / load_valid in IDLE ----------------
        reset_ctrl = 1'b1;
        @(negedge CLK);
        reset_ctrl = 1'b0;
        @(negedge CLK);
        instr_addr = 16'd0;
        drive_load(9'h077, 1'b1);
        check("idle done state", dbg_state, ST_IDLE);
        check("idle done prog_len", prog_len, 11'd0);
        check("idle done load_ready", load_ready, 1'b0);
        check("idle done fetch_stall", fetch_stall, 1'b1);
        check("idle fetch ignored", instr_valid, 1'b0);
        check("idle instr_out", instr_out, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
